// File: rtl/hd44780_responder.sv
// hd44780_responder: device-side model of the HD44780 8-bit parallel LCD bus.
// It captures host writes on the falling edge of EN and decodes the instruction set.
// It keeps an 80-byte DDRAM, the address counter and a busy timer, and it flags host
// protocol errors.
// Optional feature: define HD44780_TIMING_CHECK_EN to enable the Tas/PWeh checks that
// drive err_timing. Without the macro, err_timing is tied low.
module hd44780_responder #(
    parameter int CLK_FREQ_MZ   = 50,
    parameter int BUSY_DATA_NS  = 43000,
    parameter int BUSY_INSTR_NS = 1530000,
    parameter int TAS_NS        = 40,
    parameter int PWEH_NS       = 230
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_data,
    input  logic       lcd_en,
    input  logic       lcd_rw,
    input  logic       lcd_rs,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    output logic       err_busy,
    output logic       err_addr,
    output logic       err_timing
);

    // Clocks needed to cover a duration in ns, rounded up.
    function automatic int nb_clk_for_time(input int freq_mz, input int ns);
        longint prod;
        prod = longint'(ns) * longint'(freq_mz);
        return int'((prod + 64'd999) / 64'd1000);
    endfunction

    // Index of the highest set bit (0 for values 0 and 1).
    function automatic int vect_range(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if (v >= (1 << i)) r = i;
        return r;
    endfunction

    localparam int INSTR_CLKS = nb_clk_for_time(CLK_FREQ_MZ, BUSY_INSTR_NS);
    localparam int DATA_CLKS  = nb_clk_for_time(CLK_FREQ_MZ, BUSY_DATA_NS);
    localparam int MAX_CLKS   = (INSTR_CLKS > DATA_CLKS) ? INSTR_CLKS : DATA_CLKS;
    localparam int CNT_W      = vect_range(MAX_CLKS) + 1;

    // The EXEC cycle counts as the first busy clock, and the BUSY state runs one extra
    // clock when it reaches zero, so the counter is loaded with the total minus two.
    // A Clear needs INSTR_CLKS >= 82 so that the 80 fill clocks fit inside the budget.
    localparam logic [CNT_W-1:0] INSTR_LOAD = CNT_W'(INSTR_CLKS - 2);
    localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_CLKS - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_BUSY  = 2'd3;

    // The DDRAM address space has two 40-byte windows: 0x00-0x27 and 0x40-0x67.
    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return (a < 7'h40) ? a : (a - 7'h40 + 7'd40);
    endfunction

    // Address counter step, hopping between the two DDRAM windows.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h27)      n = 7'h40;
            else if (a == 7'h67) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h00)      n = 7'h67;
            else if (a == 7'h40) n = 7'h27;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             en_q;
    logic             id;
    logic [6:0]       ac;
    logic             disp;
    logic             cap_rs;
    logic [7:0]       cap_data;
    logic [6:0]       clr_idx;
    logic [7:0]       ddram [0:79];
    logic             capture;

    assign capture     = en_q && !lcd_en && !lcd_rw;
    assign busy        = (state != S_IDLE);
    assign cursor_addr = ac;
    assign display_on  = disp;
    assign cmd_valid   = (state == S_EXEC);
    assign cmd_rs      = cap_rs;
    assign cmd_data    = cap_data;
    assign err_busy    = capture && busy && !reset;
    assign err_addr    = (state == S_EXEC) && !cap_rs && cap_data[7] && !addr_valid(cap_data[6:0]);

    // Control FSM: capture, decode, clear fill and busy countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            en_q     <= 1'b0;
            id       <= 1'b1;
            ac       <= 7'h00;
            disp     <= 1'b0;
            cap_rs   <= 1'b0;
            cap_data <= 8'h00;
            clr_idx  <= 7'd0;
        end else begin
            en_q <= lcd_en;
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        cap_rs   <= lcd_rs;
                        cap_data <= lcd_data;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_BUSY;
                    cnt   <= DATA_LOAD;
                    if (cap_rs) begin
                        ac <= ac_step(ac, id);
                    end else if (cap_data[7]) begin
                        if (addr_valid(cap_data[6:0])) ac <= cap_data[6:0];
                    end else if (cap_data[6] || cap_data[5] || cap_data[4]) begin
                        // CGRAM address, function set, shift: accepted without effect
                    end else if (cap_data[3]) begin
                        disp <= cap_data[2];
                    end else if (cap_data[2]) begin
                        id <= cap_data[1];
                    end else if (cap_data[1]) begin
                        ac  <= 7'h00;
                        cnt <= INSTR_LOAD;
                    end else if (cap_data[0]) begin
                        ac      <= 7'h00;
                        id      <= 1'b1;
                        cnt     <= INSTR_LOAD;
                        clr_idx <= 7'd0;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt <= cnt - 1'b1;
                    if (clr_idx == 7'd79) state <= S_BUSY;
                    else                  clr_idx <= clr_idx + 7'd1;
                end
                default: begin
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
            endcase
        end
    end

    // DDRAM writes: data bytes from EXEC and blanks from the Clear fill. A reset stops the fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state == S_EXEC) && cap_rs)
                ddram[ddram_index(ac)] <= cap_data;
            else if (state == S_CLEAR)
                ddram[clr_idx] <= 8'h20;
        end
    end

    // Registered DDRAM inspect port. Addresses outside both windows read as 0x00.
    always_ff @(posedge clk) begin
        if (reset)                 rd_char <= 8'h00;
        else if (addr_valid(rd_addr)) rd_char <= ddram[ddram_index(rd_addr)];
        else                       rd_char <= 8'h00;
    end

`ifdef HD44780_TIMING_CHECK_EN
    localparam int TAS_CLKS  = nb_clk_for_time(CLK_FREQ_MZ, TAS_NS);
    localparam int PWEH_CLKS = nb_clk_for_time(CLK_FREQ_MZ, PWEH_NS);
    localparam int TMAX      = (TAS_CLKS > PWEH_CLKS) ? TAS_CLKS : PWEH_CLKS;
    localparam int TW        = vect_range(TMAX) + 2;
    localparam logic [TW-1:0] TSAT = '1;

    logic          rs_q;
    logic [TW-1:0] stab_cnt;
    logic [TW-1:0] setup_lat;
    logic [TW-1:0] hi_cnt;

    // Measure RS stability and latch it at EN rise. Also measure the EN high width.
    // Both counters saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_q      <= 1'b0;
            stab_cnt  <= '0;
            setup_lat <= '0;
            hi_cnt    <= '0;
        end else begin
            rs_q <= lcd_rs;
            if (lcd_rs != rs_q)      stab_cnt <= '0;
            else if (stab_cnt != TSAT) stab_cnt <= stab_cnt + 1'b1;
            if (lcd_en && !en_q)     setup_lat <= stab_cnt;
            if (!lcd_en)             hi_cnt <= '0;
            else if (hi_cnt != TSAT) hi_cnt <= hi_cnt + 1'b1;
        end
    end

    assign err_timing = capture && !reset &&
                        ((int'(setup_lat) < TAS_CLKS) || (int'(hi_cnt) < PWEH_CLKS));
`else
    assign err_timing = 1'b0;
`endif

endmodule

// File: tb/tb_hd44780_responder.sv
// Scoreboard bench for hd44780_responder (50 MHz, 100-clk instruction / 50-clk data busy).
// Stimulus pushes expected bus events into a queue, and a negedge monitor pops and compares them.
module tb_hd44780_responder;

    logic       clk;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_en;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [6:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy;
    logic [6:0] cursor_addr;
    logic       display_on;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       err_busy;
    logic       err_addr;
    logic       err_timing;

    hd44780_responder #(
        .CLK_FREQ_MZ  (50),
        .BUSY_DATA_NS (1000),
        .BUSY_INSTR_NS(2000),
        .TAS_NS       (40),
        .PWEH_NS      (230)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_data   (lcd_data),
        .lcd_en     (lcd_en),
        .lcd_rw     (lcd_rw),
        .lcd_rs     (lcd_rs),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .busy       (busy),
        .cursor_addr(cursor_addr),
        .display_on (display_on),
        .cmd_valid  (cmd_valid),
        .cmd_rs     (cmd_rs),
        .cmd_data   (cmd_data),
        .err_busy   (err_busy),
        .err_addr   (err_addr),
        .err_timing (err_timing)
    );

    localparam logic [1:0] EV_CMD = 2'd0, EV_BUSY = 2'd1, EV_ADDR = 2'd2, EV_TIM = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       rs;
        logic [7:0] data;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic rs, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.rs   = rs;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic mon_check(input logic [1:0] kind, input logic rs, input logic [7:0] d);
        ev_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d rs=%0d data=0x%h, required no event", kind, rs, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind == EV_CMD && (e.rs != rs || e.data != d))) begin
                n_fail++;
                $display("FAIL event: got kind=%0d rs=%0d data=0x%h, required kind=%0d rs=%0d data=0x%h",
                         kind, rs, d, e.kind, e.rs, e.data);
            end
        end
    endtask

    // Monitor: every pulse on the DUT's event outputs must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid)  mon_check(EV_CMD, cmd_rs, cmd_data);
            if (err_busy)   mon_check(EV_BUSY, 1'b0, 8'h00);
            if (err_addr)   mon_check(EV_ADDR, 1'b0, 8'h00);
            if (err_timing) mon_check(EV_TIM, 1'b0, 8'h00);
        end
    end

    task automatic host_cycle(input logic rw, input logic rs, input logic [7:0] d, input int hi);
        @(posedge clk); #1;
        lcd_rw = rw; lcd_rs = rs; lcd_data = d;
        repeat (4) @(posedge clk);
        #1 lcd_en = 1'b1;
        repeat (hi) @(posedge clk);
        #1 lcd_en = 1'b0;
    endtask

    task automatic host_write(input logic rs, input logic [7:0] d);
        host_cycle(1'b0, rs, d, 14);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got busy=1 after 500 clks, required busy=0");
        end
    endtask

    task automatic chk_mem(input logic [6:0] a, input logic [7:0] exp);
        @(negedge clk) rd_addr = a;
        @(negedge clk);
        chk($sformatf("ddram[0x%h]", a), {24'd0, rd_char}, {24'd0, exp});
    endtask

    initial begin
        int cnt;
        reset = 1'b1; lcd_data = 8'h00; lcd_en = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0; rd_addr = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cursor", {25'd0, cursor_addr}, 32'd0);
        chk("rst_display", {31'd0, display_on}, 32'd0);
        chk("rst_cmd", {22'd0, cmd_valid, cmd_rs, cmd_data}, 32'd0);
        chk("rst_err", {29'd0, err_busy, err_addr, err_timing}, 32'd0);
        chk("rst_rd_char", {24'd0, rd_char}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Clear: busy for exactly 100 clocks, then every byte blank
        push(EV_CMD, 1'b0, 8'h01);
        host_write(1'b0, 8'h01);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        chk("clear_busy_clks", cnt, 32'd100);
        chk_mem(7'h00, 8'h20);
        chk_mem(7'h27, 8'h20);
        chk_mem(7'h40, 8'h20);
        chk_mem(7'h67, 8'h20);
        chk_mem(7'h30, 8'h00);
        chk("clear_cursor", {25'd0, cursor_addr}, 32'h00);

        // Set AC=0x27, then two data bytes that cross into the second line
        push(EV_CMD, 1'b0, 8'hA7); host_write(1'b0, 8'hA7); wait_idle();
        chk("seta_cursor", {25'd0, cursor_addr}, 32'h27);
        push(EV_CMD, 1'b1, 8'h41); host_write(1'b1, 8'h41); wait_idle();
        chk("wrap_cursor", {25'd0, cursor_addr}, 32'h40);
        push(EV_CMD, 1'b1, 8'h42); host_write(1'b1, 8'h42); wait_idle();
        chk("inc_cursor", {25'd0, cursor_addr}, 32'h41);
        chk_mem(7'h27, 8'h41);
        chk_mem(7'h40, 8'h42);

        // Decrement mode, AC=0, then a data write wraps AC down to 0x67
        push(EV_CMD, 1'b0, 8'h04); host_write(1'b0, 8'h04); wait_idle();
        push(EV_CMD, 1'b0, 8'h80); host_write(1'b0, 8'h80); wait_idle();
        chk("home_via_seta", {25'd0, cursor_addr}, 32'h00);
        push(EV_CMD, 1'b1, 8'h5A); host_write(1'b1, 8'h5A); wait_idle();
        chk_mem(7'h00, 8'h5A);
        chk("dec_wrap_cursor", {25'd0, cursor_addr}, 32'h67);

        // Display control
        push(EV_CMD, 1'b0, 8'h0C); host_write(1'b0, 8'h0C); wait_idle();
        chk("display_on", {31'd0, display_on}, 32'd1);

        // Write while busy: the second byte is dropped with err_busy
        push(EV_CMD, 1'b1, 8'h33);
        host_write(1'b1, 8'h33);
        push(EV_BUSY, 1'b0, 8'h00);
        host_write(1'b1, 8'h34);
        wait_idle();
        chk_mem(7'h67, 8'h33);
        chk_mem(7'h66, 8'h20);
        chk("busy_drop_cursor", {25'd0, cursor_addr}, 32'h66);

        // Read cycles (RW=1) are ignored entirely
        host_cycle(1'b1, 1'b1, 8'h99, 14);
        repeat (4) @(negedge clk);
        chk("rw_ignored_cursor", {25'd0, cursor_addr}, 32'h66);

        // Set DDRAM address 0x30 is outside both windows
        push(EV_CMD, 1'b0, 8'hB0);
        push(EV_ADDR, 1'b0, 8'h00);
        host_write(1'b0, 8'hB0);
        wait_idle();
        chk("bad_addr_cursor", {25'd0, cursor_addr}, 32'h66);

`ifdef HD44780_TIMING_CHECK_EN
        // EN held high for only 5 clocks: flagged, but still executed
        push(EV_TIM, 1'b0, 8'h00);
        push(EV_CMD, 1'b0, 8'h00);
        host_cycle(1'b0, 1'b0, 8'h00, 5);
        wait_idle();
`endif

        // Reset 30 clocks into a Clear, then a normal write
        push(EV_CMD, 1'b0, 8'h01);
        host_write(1'b0, 8'h01);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cursor", {25'd0, cursor_addr}, 32'h00);
        chk("abort_display", {31'd0, display_on}, 32'd0);
        push(EV_CMD, 1'b1, 8'h77); host_write(1'b1, 8'h77); wait_idle();
        chk("post_reset_cursor", {25'd0, cursor_addr}, 32'h01);
        chk_mem(7'h00, 8'h77);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
